// File: rtl/zmod_rxalign.sv
`default_nettype none
// ============================================================================
// Module  : zmod_rxalign
// Brief   : Receive word-alignment controller. Holds the deserializer in
//           reset until the MMCM locks, then bitslips until a training word
//           is seen MATCH_COUNT times in a row.
// Rev     : 1.0  initial release
// ============================================================================
module zmod_rxalign #(
  parameter int             W             = 8,
  parameter logic [W-1:0]   TRAIN_PATTERN = 8'h5C,
  parameter int             RST_CYCLES    = 16,
  parameter int             SETTLE_CYCLES = 8,
  parameter int             MATCH_COUNT   = 4,
  parameter int             SLIP_WAIT     = 4,
  parameter int             MAX_SLIPS     = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          locked,
  input  logic          realign,
  input  logic [W-1:0]  rx_data,
  output logic          serdes_rst,
  output logic          bitslip,
  output logic          aligned,
  output logic [W-1:0]  data_out,
  output logic          data_valid,
  output logic [3:0]    slip_count,
  output logic [7:0]    retry_count
);

  localparam int c_CNT_MAX = (RST_CYCLES > SETTLE_CYCLES)
                           ? ((RST_CYCLES > SLIP_WAIT) ? RST_CYCLES : SLIP_WAIT)
                           : ((SETTLE_CYCLES > SLIP_WAIT) ? SETTLE_CYCLES : SLIP_WAIT);
  localparam int c_CNT_W   = $clog2(c_CNT_MAX + 1);
  localparam int c_MATCH_W = $clog2(MATCH_COUNT + 1);

  localparam logic [c_CNT_W-1:0]   c_RST_LOAD    = c_CNT_W'(RST_CYCLES - 1);
  localparam logic [c_CNT_W-1:0]   c_SETTLE_LOAD = c_CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [c_CNT_W-1:0]   c_SLIP_LOAD   = c_CNT_W'(SLIP_WAIT - 1);
  localparam logic [c_MATCH_W-1:0] c_MATCH_LAST  = c_MATCH_W'(MATCH_COUNT - 1);
  localparam logic [3:0]           c_MAX_SLIPS   = 4'(MAX_SLIPS);

  typedef enum logic [2:0] {
    S_WAIT_LOCK = 3'd0,
    S_RST       = 3'd1,
    S_SETTLE    = 3'd2,
    S_CHECK     = 3'd3,
    S_SLIP      = 3'd4,
    S_SLIP_WAIT = 3'd5,
    S_ALIGNED   = 3'd6
  } state_t;

  state_t                r_state;
  logic [c_CNT_W-1:0]    r_cnt;
  logic [c_MATCH_W-1:0]  r_match;
  logic                  r_lock_meta;
  logic                  r_lock_s;

  // locked comes straight from the MMCM and is asynchronous to clk
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lock_meta <= 1'b0;
      r_lock_s    <= 1'b0;
    end else begin
      r_lock_meta <= locked;
      r_lock_s    <= r_lock_meta;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out <= '0;
    end else begin
      data_out <= rx_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_WAIT_LOCK;
      r_cnt       <= '0;
      r_match     <= '0;
      serdes_rst  <= 1'b1;
      bitslip     <= 1'b0;
      aligned     <= 1'b0;
      data_valid  <= 1'b0;
      slip_count  <= '0;
      retry_count <= '0;
    end else if (!r_lock_s) begin
      r_state    <= S_WAIT_LOCK;
      serdes_rst <= 1'b1;
      bitslip    <= 1'b0;
      aligned    <= 1'b0;
      data_valid <= 1'b0;
      slip_count <= '0;
    end else if (realign && (r_state != S_WAIT_LOCK)) begin
      r_state    <= S_RST;
      r_cnt      <= c_RST_LOAD;
      serdes_rst <= 1'b1;
      bitslip    <= 1'b0;
      aligned    <= 1'b0;
      data_valid <= 1'b0;
      slip_count <= '0;
    end else begin
      case (r_state)
        S_WAIT_LOCK: begin
          serdes_rst <= 1'b1;
          r_cnt      <= c_RST_LOAD;
          r_state    <= S_RST;
        end
        S_RST: begin
          if (r_cnt == '0) begin
            serdes_rst <= 1'b0;
            r_cnt      <= c_SETTLE_LOAD;
            r_state    <= S_SETTLE;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_SETTLE: begin
          r_match <= '0;
          if (r_cnt == '0) begin
            r_state <= S_CHECK;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_CHECK: begin
          if (rx_data == TRAIN_PATTERN) begin
            if (r_match == c_MATCH_LAST) begin
              aligned    <= 1'b1;
              data_valid <= 1'b1;
              r_state    <= S_ALIGNED;
            end else begin
              r_match <= r_match + 1'b1;
            end
          end else if (slip_count < c_MAX_SLIPS) begin
            bitslip <= 1'b1;
            r_state <= S_SLIP;
          end else begin
            // out of slips: restart the deserializer from scratch
            slip_count <= '0;
            if (retry_count != 8'hFF) begin
              retry_count <= retry_count + 8'd1;
            end
            serdes_rst <= 1'b1;
            r_cnt      <= c_RST_LOAD;
            r_state    <= S_RST;
          end
        end
        S_SLIP: begin
          bitslip    <= 1'b0;
          slip_count <= slip_count + 4'd1;
          r_cnt      <= c_SLIP_LOAD;
          r_state    <= S_SLIP_WAIT;
        end
        S_SLIP_WAIT: begin
          r_match <= '0;
          if (r_cnt == '0) begin
            r_state <= S_CHECK;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_ALIGNED: begin
          aligned    <= 1'b1;
          data_valid <= 1'b1;
        end
        default: begin
          serdes_rst <= 1'b1;
          r_state    <= S_WAIT_LOCK;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
